// File: rtl/up_counter_ctrl.sv
// rtl/up_counter_ctrl.sv - prescaled up-counter sequencer with start/stop/clear and terminal value
//
// Purpose: owns a CNT_W-bit count register advanced once per prescaler period
// (2**DIV_W clk cycles) while running; sequences IDLE/RUN/PAUSE/DONE from
// level commands, with a latched terminal value and optional wrap-around.
//
// Ports:
//   clk    in   system clock, all flops on posedge
//   rst    in   synchronous active-low reset
//   start  in   start from IDLE/DONE (count from 0) or resume from PAUSE
//   stop   in   RUN -> PAUSE
//   clear  in   any state -> IDLE, count zeroed
//   limit  in   terminal count, latched on start from IDLE/DONE
//   wrap   in   latched with limit; 1 = roll to 0 at limit, 0 = halt in DONE
//   out    out  current count
//   busy   out  high in RUN and PAUSE
//   done   out  one-cycle registered pulse after the terminating tick
//   tick   out  count enable, high for one cycle per prescaler period in RUN
module up_counter_ctrl #(
    parameter int DIV_W = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    input  logic             wrap,
    output logic [CNT_W-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             tick
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] out_q,   out_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             wrap_q,  wrap_d;
    logic             done_q,  done_d;

    // The prescaler only advances in RUN, so its all-ones value is the tick.
    assign tick = (state_q == ST_RUN) && (&presc_q);
    assign out  = out_q;
    assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        out_d   = out_q;
        limit_d = limit_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            out_d   = '0;
        end else if (stop) begin
            // Stop outranks start in every state; in RUN it freezes the
            // prescaler and count, so a coincident tick is deferred until
            // the first cycle after resume.
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            state_d = ST_RUN;
            presc_d = '0;
            out_d   = '0;
            limit_d = limit;
            wrap_d  = wrap;
        end else if (start && state_q == ST_PAUSE) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            presc_d = presc_q + 1'b1;
            if (tick) begin
                if (out_q != limit_q) begin
                    out_d = out_q + 1'b1;
                end else if (wrap_q) begin
                    out_d  = '0;
                    done_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            out_q   <= '0;
            limit_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            out_q   <= out_d;
            limit_q <= limit_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_up_counter_ctrl.sv
// tb/tb_up_counter_ctrl.sv - scoreboard bench for up_counter_ctrl with directed and random commands
module tb_up_counter_ctrl;

    localparam int DIV_W  = 2;
    localparam int CNT_W  = 4;
    localparam int PERIOD = 1 << DIV_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] limit = '0;
    logic             wrap = 1'b0;
    logic [CNT_W-1:0] out;
    logic             busy;
    logic             done;
    logic             tick;

    up_counter_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .limit(limit), .wrap(wrap), .out(out), .busy(busy), .done(done), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] out;
        logic             busy;
        logic             done;
        logic             tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: mode 0 idle, 1 running, 2 paused, 3 finished.
    // phase counts cycles spent running within the current prescaler period.
    int m_mode  = 0;
    int m_cnt   = 0;
    int m_phase = 0;
    int m_lim   = 0;
    int m_wrap  = 0;
    int m_done  = 0;

    task automatic model_edge(input bit r, input bit s, input bit p, input bit c,
                              input int l, input bit w);
        m_done = 0;
        if (!r) begin
            m_mode = 0; m_cnt = 0; m_phase = 0; m_lim = 0; m_wrap = 0;
        end else if (c) begin
            m_mode = 0; m_cnt = 0; m_phase = 0;
        end else if (p) begin
            if (m_mode == 1) m_mode = 2;
        end else if (s && (m_mode == 0 || m_mode == 3)) begin
            m_mode = 1; m_cnt = 0; m_phase = 0; m_lim = l; m_wrap = w;
        end else if (s && m_mode == 2) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_phase == PERIOD - 1) begin
                if (m_cnt != m_lim) begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end else begin
                    m_done = 1;
                    if (m_wrap) m_cnt = 0;
                    else        m_mode = 3;
                end
            end
            m_phase = (m_phase + 1) % PERIOD;
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit c,
                        input int l, input bit w);
        exp_t e;
        rst = r; start = s; stop = p; clear = c; limit = l[CNT_W-1:0]; wrap = w;
        model_edge(r, s, p, c, l, w);
        e.out  = m_cnt[CNT_W-1:0];
        e.busy = (m_mode == 1 || m_mode == 2);
        e.done = (m_done != 0);
        e.tick = (m_mode == 1 && m_phase == PERIOD - 1);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle is an output beat; compare against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out !== e.out || busy !== e.busy || done !== e.done || tick !== e.tick) begin
                    failures++;
                    $display("FAIL cycle%0d outputs: got out=%0d busy=%b done=%b tick=%b want out=%0d busy=%b done=%b tick=%b",
                             cyc, out, busy, done, tick, e.out, e.busy, e.done, e.tick);
                end
            end
        end
    end

    initial begin : driver
        // Reset held with start asserted: commands ignored.
        step(0, 1, 0, 0, 5, 1);
        step(0, 1, 0, 0, 5, 1);

        // Halt at limit 5.
        step(1, 1, 0, 0, 5, 0);
        idle(30);

        // Wrap at full-scale limit.
        step(1, 1, 0, 0, 15, 1);
        idle(80);

        // Pause mid-period, hold, resume.
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 15, 0);
        idle(14);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 3, 1);
        idle(6);

        // Clear together with stop on a tick cycle at count 7.
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 15, 0);
        idle(31);
        step(1, 0, 1, 1, 0, 0);
        idle(3);

        // Reset mid-run with start held, then restart.
        step(1, 1, 0, 0, 15, 1);
        idle(38);
        step(0, 1, 0, 0, 15, 1);
        step(0, 1, 0, 0, 15, 1);
        step(1, 1, 0, 0, 15, 1);
        idle(6);

        // Zero limit, both wrap modes.
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        idle(12);
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        idle(8);

        // Randomized command mix.
        for (int i = 0; i < 3000; i++) begin
            int x;
            bit r, s, p, c;
            x = int'($urandom_range(0, 999));
            r = (x >= 5);
            c = ($urandom_range(0, 99) < 2);
            p = ($urandom_range(0, 99) < 5);
            s = ($urandom_range(0, 99) < 15);
            step(r, s, p, c, int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
